// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MULT/MULTU/DIV/DIVU sequencer for the EX stage (32-step restoring divide).
// Define MDU_MULT_ITER_EN to build MULT/MULTU as a 32-cycle shift-add instead of a 32x32 multiply.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

`ifdef MDU_MULT_ITER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV_ON = 2'd1, MUL_ON = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DIV_ON = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo, r_rem, r_b, r_hi, r_lo;
  logic        r_q_neg, r_r_neg, r_done, r_dbz;
  logic        w_iter, w_last, w_stall;

  // Operand magnitudes: only signed ops (op[0] == 0) take |x|.
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  assign w_a_neg = ~op[0] & src_a[31];
  assign w_b_neg = ~op[0] & src_b[31];
  assign w_a_mag = w_a_neg ? -src_a : src_a;
  assign w_b_mag = w_b_neg ? -src_b : src_b;

  // One restoring-divide step on the 33-bit shifted partial remainder.
  logic [32:0] w_shift, w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt;
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, r_b};
  assign w_ge      = ~w_diff[32];
  assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};

`ifdef MDU_MULT_ITER_EN
  // Shift-add: r_rem is the upper accumulator half, r_quo holds the multiplier then the low half.
  logic [32:0] w_sum;
  logic [63:0] w_mag, w_mul_res;
  assign w_sum     = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : 33'd0);
  assign w_mag     = {w_sum[32:1], w_sum[0], r_quo[31:1]};
  assign w_mul_res = r_q_neg ? -w_mag : w_mag;
  assign w_iter    = (r_state == DIV_ON) || (r_state == MUL_ON);
`else
  // Sign-extending to 64 bits makes one multiplier serve MULT and MULTU.
  logic [63:0] w_ext_a, w_ext_b, w_prod;
  assign w_ext_a = {{32{w_a_neg | (~op[0] & src_a[31])}}, src_a};
  assign w_ext_b = {{32{w_b_neg | (~op[0] & src_b[31])}}, src_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_iter  = (r_state == DIV_ON);
`endif

  assign w_last = (r_cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // EX holds start high until the DONE cycle; stallreq is the hold-off that keeps it there.
  always_comb begin
    w_next  = r_state;
    w_stall = ~rst & ((start & (r_state != DONE) & ~flush) | w_iter);
    unique case (r_state)
      IDLE: if (start) begin
        if (op[1]) w_next = (src_b == 32'd0) ? DONE : DIV_ON;
`ifdef MDU_MULT_ITER_EN
        else       w_next = MUL_ON;
`else
        else       w_next = DONE;
`endif
      end
      DIV_ON: if (w_last) w_next = DONE;
`ifdef MDU_MULT_ITER_EN
      MUL_ON: if (w_last) w_next = DONE;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 5'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= (w_next == DONE);
      unique case (r_state)
        IDLE: if (start && !flush) begin
          r_cnt   <= 5'd0;
          r_quo   <= w_a_mag;
          r_b     <= w_b_mag;
          r_rem   <= 32'd0;
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
          if (op[1] && (src_b == 32'd0)) begin
            r_hi  <= src_a;
            r_lo  <= 32'hFFFF_FFFF;
            r_dbz <= 1'b1;
          end
`ifndef MDU_MULT_ITER_EN
          else if (!op[1]) begin
            r_hi  <= w_prod[63:32];
            r_lo  <= w_prod[31:0];
            r_dbz <= 1'b0;
          end
`endif
        end
        DIV_ON: if (!flush) begin
          r_cnt <= r_cnt + 5'd1;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (w_last) begin
            r_lo  <= r_q_neg ? -w_quo_nxt : w_quo_nxt;
            r_hi  <= r_r_neg ? -w_rem_nxt : w_rem_nxt;
            r_dbz <= 1'b0;
          end
        end
`ifdef MDU_MULT_ITER_EN
        MUL_ON: if (!flush) begin
          r_cnt <= r_cnt + 5'd1;
          r_rem <= w_sum[32:1];
          r_quo <= {w_sum[0], r_quo[31:1]};
          if (w_last) begin
            r_hi  <= w_mul_res[63:32];
            r_lo  <= w_mul_res[31:0];
            r_dbz <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign stallreq    = w_stall;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors with literal expectations plus a per-cycle compare
// against a timeline/arithmetic model of mdu_ctrl.
module tb_mdu_ctrl;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

`ifdef MDU_MULT_ITER_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stallreq(stallreq), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // model: arithmetic result {dbz, hi, lo} and latency to the done cycle
  function automatic logic [64:0] model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    if (o[1]) return (b == 32'd0) ? 1 : 33;
    return MUL_LAT;
  endfunction

  // scoreboard
  logic [64:0] exp_q[$];
  logic [64:0] e_res;
  bit          m_active = 1'b0;
  int          m_k = 0, m_lat = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        e_busy, e_done, e_stall;

  always @(negedge clk) begin
    if (rst) begin
      chk("stallreq_in_rst", 64'(stallreq), 64'd0);
      m_active = 1'b0;
      m_k      = 0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
      exp_q.delete();
    end else begin
      if (!m_active) begin
        e_busy = 1'b0; e_done = 1'b0; e_stall = start & ~flush;
      end else if (m_k < m_lat) begin
        e_busy = 1'b1; e_done = 1'b0; e_stall = 1'b1;
      end else begin
        e_busy = 1'b1; e_done = 1'b1; e_stall = 1'b0;
      end
      chk("stallreq", 64'(stallreq), 64'(e_stall));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      if (e_done && exp_q.size() > 0) begin
        e_res = exp_q.pop_front();
        m_hi  = e_res[63:32];
        m_lo  = e_res[31:0];
        chk("div_by_zero", 64'(div_by_zero), 64'(e_res[64]));
      end
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (!m_active) begin
        if (start && !flush) begin
          exp_q.push_back(model_result(op, src_a, src_b));
          m_lat    = model_lat(op, src_b);
          m_k      = 1;
          m_active = 1'b1;
        end
      end else if (flush && m_k < m_lat) begin
        m_active = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (m_k >= m_lat) begin
        m_active = 1'b0;
      end else begin
        m_k++;
      end
    end
  end

  // driver tasks
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat);
    int  k, st;
    bit  seen;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    k = 0; st = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (stallreq) st++;
      if (done) seen = 1'b1;
      else k++;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_done_cycle"}, 64'(k), 64'(elat));
    chk({name, "_stall_cycles"}, 64'(st), 64'(elat));
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
    chk({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic abort_div(input string name, input bit use_rst,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int dn;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_stallreq"}, 64'(stallreq), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk({name, "_no_done"}, 64'(dn), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stallreq", 64'(stallreq), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_dbg_state_idle", 64'(dbg_state), 64'd0);

    run_op("divu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33);
    run_op("div_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0, 33);
    run_op("div_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  32'h8000_0000,  1'b0, 33);
    run_op("div_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  1'b0, 33);
    run_op("div_0_5",      2'b10, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33);
    run_op("divu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 1);
    run_op("div_m7_0",     2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  1'b1, 1);
    run_op("mult_m3_m4",   2'b00, 32'hFFFF_FFFD,  32'hFFFF_FFFC,  32'd0,          32'd12,         1'b0, MUL_LAT);
    run_op("mult_m1_2",    2'b00, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, MUL_LAT);
    run_op("multu_ff_2",   2'b01, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE,  1'b0, MUL_LAT);

    abort_div("flush_mid", 1'b0, 32'd1, 32'hFFFF_FFFE);
    abort_div("rst_mid",   1'b1, 32'd0, 32'd0);

    run_op("divu_again",   2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
